// File: rtl/draw_letters.sv
// draw_letters: aligns the VGA bus to the font-ROM latency and overlays the A-H / 1-8 board labels.
// Optional macro LETTER_SHADOW_EN adds a 1-px right-hand drop shadow in SHADOW_COLOR.
module draw_letters #(
    parameter int unsigned ROM_LAT      = 1,
    parameter logic [11:0] LETTER_COLOR = 12'hFFF
`ifdef LETTER_SHADOW_EN
    ,
    parameter logic [11:0] SHADOW_COLOR = 12'h222
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [7:0]  char_pixels,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out
);

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
        logic        region;
        logic [2:0]  col;
    } pix_t;

    localparam int unsigned PIPE_W = ROM_LAT * $bits(pix_t);

    pix_t                   stage0;
    pix_t [ROM_LAT-1:0]     pipe;
    pix_t                   aligned;
    logic [5:0]             hm;
    logic [5:0]             vm;
    logic                   in_top_bottom;
    logic                   side_rows;
    logic                   in_left;
    logic                   in_right;
    logic                   glyph_bit;
    logic [11:0]            rgb_next;

    // Label region / glyph column decode on the undelayed coordinates.
    always_comb begin
        hm = hcount_in[5:0];
        vm = vcount_in[5:0];

        in_top_bottom = (hcount_in >= 11'd256) && (hcount_in <= 11'd768)
                     && (((vcount_in >= 11'd104) && (vcount_in <= 11'd120))
                      || ((vcount_in >= 11'd648) && (vcount_in <= 11'd664)))
                     && (hm >= 6'd28) && (hm <= 6'd35);
        side_rows = (vcount_in >= 11'd128) && (vcount_in <= 11'd640)
                 && (vm >= 6'd24) && (vm <= 6'd40);
        in_left  = side_rows && (hcount_in >= 11'd236) && (hcount_in <= 11'd243);
        in_right = side_rows && (hcount_in >= 11'd780) && (hcount_in <= 11'd787);

        stage0        = '0;
        stage0.vcount = vcount_in;
        stage0.vsync  = vsync_in;
        stage0.vblnk  = vblnk_in;
        stage0.hcount = hcount_in;
        stage0.hsync  = hsync_in;
        stage0.hblnk  = hblnk_in;
        stage0.rgb    = rgb_in;
        stage0.region = in_top_bottom || in_left || in_right;
        if (in_top_bottom) begin
            stage0.col = 3'(hm - 6'd28);
        end else if (in_left) begin
            stage0.col = 3'(hcount_in - 11'd236);
        end else if (in_right) begin
            stage0.col = 3'(hcount_in - 11'd780);
        end
    end

    assign aligned = pipe[ROM_LAT-1];

    always_comb begin
        glyph_bit = char_pixels[3'd7 - aligned.col];
        rgb_next  = aligned.rgb;
        if (aligned.hblnk || aligned.vblnk) begin
            rgb_next = '0;
        end else if (aligned.region && glyph_bit) begin
            rgb_next = LETTER_COLOR;
        end
`ifdef LETTER_SHADOW_EN
        else if (aligned.region && (aligned.col != 3'd0)
                 && char_pixels[3'(4'd8 - {1'b0, aligned.col})]) begin
            rgb_next = SHADOW_COLOR;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe       <= '0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            // New pixel enters element 0; the oldest element falls off the top.
            pipe       <= PIPE_W'({pipe, stage0});
            vcount_out <= aligned.vcount;
            vsync_out  <= aligned.vsync;
            vblnk_out  <= aligned.vblnk;
            hcount_out <= aligned.hcount;
            hsync_out  <= aligned.hsync;
            hblnk_out  <= aligned.hblnk;
            rgb_out    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_letters.sv
// Self-checking bench for draw_letters: ROM_LAT=1 and ROM_LAT=3 instances against a reference model.
module tb_draw_letters;

    localparam logic [11:0] LETTER = 12'hFFF;
    localparam logic [11:0] SHADOW = 12'h222;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
        logic [11:0] rgb;
        logic [7:0]  g;
    } px_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] vcount_in = '0;
    logic        vsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  cp1 = '0;
    logic [7:0]  cp3 = '0;

    logic [10:0] vc1, hc1, vc3, hc3;
    logic        vs1, vb1, hs1, hb1, vs3, vb3, hs3, hb3;
    logic [11:0] rgb1, rgb3;

    px_t hist[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    draw_letters #(.ROM_LAT(1), .LETTER_COLOR(LETTER)) dut1 (
        .clk(clk), .rst(rst),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .char_pixels(cp1),
        .vcount_out(vc1), .vsync_out(vs1), .vblnk_out(vb1),
        .hcount_out(hc1), .hsync_out(hs1), .hblnk_out(hb1), .rgb_out(rgb1)
    );

    draw_letters #(.ROM_LAT(3), .LETTER_COLOR(LETTER)) dut3 (
        .clk(clk), .rst(rst),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .char_pixels(cp3),
        .vcount_out(vc3), .vsync_out(vs3), .vblnk_out(vb3),
        .hcount_out(hc3), .hsync_out(hs3), .hblnk_out(hb3), .rgb_out(rgb3)
    );

    function automatic px_t mk(int h, int v, bit hb, bit vb, int rgb, int g);
        px_t p;
        p.h   = 11'(h);
        p.v   = 11'(v);
        p.hs  = 1'b0;
        p.vs  = 1'b0;
        p.hb  = hb;
        p.vb  = vb;
        p.rgb = 12'(rgb);
        p.g   = 8'(g);
        return p;
    endfunction

    // Reference colour computed straight from the label geometry.
    function automatic logic [11:0] model_rgb(px_t p);
        int h, v, hm, vm, col;
        bit region;
        h = int'(p.h);
        v = int'(p.v);
        hm = h % 64;
        vm = v % 64;
        region = 0;
        col = 0;
        if (p.hb || p.vb) return 12'h000;
        if (h >= 256 && h <= 768 && ((v >= 104 && v <= 120) || (v >= 648 && v <= 664))
            && hm >= 28 && hm <= 35) begin
            region = 1; col = hm - 28;
        end else if (v >= 128 && v <= 640 && vm >= 24 && vm <= 40) begin
            if (h >= 236 && h <= 243) begin region = 1; col = h - 236; end
            else if (h >= 780 && h <= 787) begin region = 1; col = h - 780; end
        end
        if (region && p.g[7-col]) return LETTER;
`ifdef LETTER_SHADOW_EN
        if (region && col > 0 && p.g[8-col]) return SHADOW;
`endif
        return p.rgb;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [24:0] eb;
        logic [11:0] er;
        int j;
        j = hist.size() - 2;
        if (j < 0) begin eb = '0; er = '0; end
        else begin
            eb = {hist[j].v, hist[j].vs, hist[j].vb, hist[j].h, hist[j].hs, hist[j].hb};
            er = model_rgb(hist[j]);
        end
        chk("bus_lat1", 32'({vc1, vs1, vb1, hc1, hs1, hb1}), 32'(eb));
        chk("rgb_lat1", 32'(rgb1), 32'(er));
        j = hist.size() - 4;
        if (j < 0) begin eb = '0; er = '0; end
        else begin
            eb = {hist[j].v, hist[j].vs, hist[j].vb, hist[j].h, hist[j].hs, hist[j].hb};
            er = model_rgb(hist[j]);
        end
        chk("bus_lat3", 32'({vc3, vs3, vb3, hc3, hs3, hb3}), 32'(eb));
        chk("rgb_lat3", 32'(rgb3), 32'(er));
    endtask

    // One pixel clock: drive the pixel and the ROM rows due now, then check after the edge.
    task automatic step(input px_t p);
        vcount_in = p.v;  vsync_in = p.vs; vblnk_in = p.vb;
        hcount_in = p.h;  hsync_in = p.hs; hblnk_in = p.hb;
        rgb_in    = p.rgb;
        cp1 = (hist.size() >= 1) ? hist[hist.size()-1].g : 8'h00;
        cp3 = (hist.size() >= 3) ? hist[hist.size()-3].g : 8'h00;
        hist.push_back(p);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_lat1"}, 32'({vc1, vs1, vb1, hc1, hs1, hb1, rgb1}), 32'h0);
        chk({tag, "_lat3"}, 32'({vc3, vs3, vb3, hc3, hs3, hb3, rgb3}), 32'h0);
    endtask

    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        hist.delete();
        rst = 1'b0;
    endtask

    function automatic px_t rand_px();
        px_t p;
        int k;
        k = int'($urandom_range(0, 3));
        case (k)
            0: p.v = 11'($urandom_range(100, 125));
            1: p.v = 11'($urandom_range(644, 668));
            2: p.v = 11'(128 + 64 * int'($urandom_range(0, 7)) + int'($urandom_range(20, 44)));
            default: p.v = 11'($urandom_range(0, 767));
        endcase
        k = int'($urandom_range(0, 3));
        case (k)
            0: p.h = 11'($urandom_range(230, 250));
            1: p.h = 11'($urandom_range(775, 792));
            2: p.h = 11'(64 * int'($urandom_range(3, 12)) + int'($urandom_range(24, 40)));
            default: p.h = 11'($urandom_range(0, 1023));
        endcase
        p.hs  = 1'($urandom_range(0, 1));
        p.vs  = 1'($urandom_range(0, 1));
        p.hb  = ($urandom_range(0, 7) == 0);
        p.vb  = ($urandom_range(0, 7) == 0);
        p.rgb = 12'($urandom);
        p.g   = 8'($urandom);
        return p;
    endfunction

    initial begin
        px_t p;
        #2;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Top label, column 0 then column 1.
        step(mk(284, 110, 0, 0, 12'h0A0, 8'h80));
        step(mk(285, 110, 0, 0, 12'h0A0, 8'h80));
        chk("top_col0_rgb", 32'(rgb1), 32'hFFF);
        chk("top_col0_hcount", 32'(hc1), 32'd284);
        step(mk(285, 110, 0, 0, 12'h0A0, 8'h40));
        chk("top_col1_off", 32'(rgb1), 32'h0A0);
        step(mk(0, 0, 1, 0, 12'h123, 8'hFF));
        chk("top_col1_on", 32'(rgb1), 32'hFFF);

        // Side labels, including the never-drawn h=244 column.
        step(mk(243, 152, 0, 0, 12'h456, 8'h01));
        step(mk(244, 152, 0, 0, 12'h456, 8'hFF));
        chk("left_col7", 32'(rgb1), 32'hFFF);
        step(mk(780, 152, 0, 0, 12'h456, 8'h80));
        chk("h244_passthru", 32'(rgb1), 32'h456);
        step(mk(788, 152, 0, 0, 12'h789, 8'hFF));
        chk("right_col0", 32'(rgb1), 32'hFFF);
        step(mk(0, 0, 0, 1, 12'h789, 8'hFF));
        chk("h788_passthru", 32'(rgb1), 32'h789);

        // Shadow candidate pixel.
        step(mk(285, 110, 0, 0, 12'h0A0, 8'h80));
        step(mk(0, 0, 1, 1, 12'h000, 8'h00));
`ifdef LETTER_SHADOW_EN
        chk("shadow_col1", 32'(rgb1), 32'h222);
`else
        chk("shadow_col1", 32'(rgb1), 32'h0A0);
`endif

        // Line scans through the label rows with horizontal blanking.
        foreach (hist[i]) ;
        for (int line = 0; line < 3; line++) begin
            for (int h = 0; h < 1056; h++) begin
                p = mk(h, (line == 0) ? 110 : (line == 1) ? 152 : 664, h >= 1024, 0,
                       int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)));
                p.hs = (h >= 1048);
                step(p);
            end
        end

        // Reset mid-line at h=300, then random traffic.
        step(mk(300, 110, 0, 0, 12'hABC, 8'hFF));
        step(mk(300, 112, 0, 0, 12'hABC, 8'hFF));
        do_reset();
        for (int n = 0; n < 3000; n++) step(rand_px());
        do_reset();
        for (int n = 0; n < 1000; n++) step(rand_px());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
